// File: rtl/snake_control_if.sv
// Signal bundle between the snake game controller and its datapath/RAM.
// Handshake semantics: tick is a one-cycle request accepted only while the
// controller idles in its wait state (no ready; requests elsewhere are dropped);
// inc_length and is_dead are qualified by check_inc and are only sampled
// during that one cycle.
interface snake_control_if;
  logic       tick;
  logic       start;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       is_dead;
  logic       inc_length;
  logic [2:0] dir;
  logic [3:0] cnt_status;
  logic [2:0] colour_in;
  logic       reset_ram;
  logic       rst_address;
  logic       inc_address;
  logic       ld_head;
  logic       ld_q_def;
  logic       draw_q;
  logic       update_head;
  logic       ld_head_into_prev;
  logic       ld_q_into_curr;
  logic       ld_prev_into_q;
  logic       ld_curr_into_prev;
  logic       draw_curr;
  logic       food_en;
  logic       lock;
  logic       check_inc;
  logic [4:0] state_dbg;

  // Controller side.
  modport master (
    input  tick, start, key_up, key_down, key_left, key_right, is_dead, inc_length,
    output dir, cnt_status, colour_in, reset_ram, rst_address, inc_address, ld_head,
           ld_q_def, draw_q, update_head, ld_head_into_prev, ld_q_into_curr,
           ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, lock, check_inc,
           state_dbg
  );

  // Datapath side.
  modport slave (
    output tick, start, key_up, key_down, key_left, key_right, is_dead, inc_length,
    input  dir, cnt_status, colour_in, reset_ram, rst_address, inc_address, ld_head,
           ld_q_def, draw_q, update_head, ld_head_into_prev, ld_q_into_curr,
           ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, lock, check_inc,
           state_dbg
  );
endinterface

// File: rtl/snake_control.sv
// Snake game controller: sequences RAM clear, body init, drawing, food,
// body shifting on each game tick, erase of the old tail and the
// collision/growth check. Every strobe is a Moore decode of the state.
module snake_control #(
  parameter int INIT_LEN    = 4,
  parameter int MAX_LEN     = 2047,
  parameter int CLEAR_WORDS = 2048
) (
  input  logic       clk,
  input  logic       rst,
  snake_control_if.master bus
);

  localparam logic [10:0] CLEAR_LAST = 11'(CLEAR_WORDS - 1);
  localparam logic [10:0] INIT_LAST  = 11'(INIT_LEN - 1);
  localparam logic [10:0] LEN_INIT   = 11'(INIT_LEN);
  localparam logic [10:0] LEN_MAX    = 11'(MAX_LEN);

  localparam logic [2:0] D_UP    = 3'b100;
  localparam logic [2:0] D_DOWN  = 3'b110;
  localparam logic [2:0] D_LEFT  = 3'b000;
  localparam logic [2:0] D_RIGHT = 3'b001;

  // Each phase is split into sub-states so that every strobe is decoded
  // from the state register alone.
  typedef enum logic [4:0] {
    S_CLEAR, S_CLEAR_END, S_INIT_HEAD, S_INIT_Q, S_INIT_END,
    S_DRAW_Q, S_DRAW_INC, S_FOOD, S_WAIT, S_MOVE,
    S_SHIFT_RD, S_SHIFT_CAP, S_SHIFT_WR, S_SHIFT_NX,
    S_ERASE, S_CHECK, S_REDRAW, S_DEAD
  } state_t;

  typedef struct packed {
    logic reset_ram;
    logic rst_address;
    logic inc_address;
    logic ld_head;
    logic ld_q_def;
    logic draw_q;
    logic update_head;
    logic ld_head_into_prev;
    logic ld_q_into_curr;
    logic ld_prev_into_q;
    logic ld_curr_into_prev;
    logic draw_curr;
    logic food_en;
    logic lock;
    logic check_inc;
  } strobe_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [10:0] idx, idx_n;
  logic [10:0] len, len_n;
  logic [2:0]  dir;
  strobe_t     stb, stb_g;
  logic [2:0]  colour, colour_g;
  logic [3:0]  keys;
  logic [2:0]  key_code;
  logic [2:0]  dir_rev;
  logic        dir_ok;

  // Controller registers; reset aborts whatever phase is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
      idx   <= '0;
      len   <= LEN_INIT;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      len   <= len_n;
    end
  end

  // Next-state/counter logic and state-decoded strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    len_n   = len;
    stb     = '0;
    colour  = 3'b000;
    case (state)
      S_CLEAR: begin
        stb.reset_ram   = 1'b1;
        stb.inc_address = 1'b1;
        if (idx == CLEAR_LAST) begin
          idx_n   = '0;
          state_n = S_CLEAR_END;
        end else begin
          idx_n = idx + 11'd1;
        end
      end
      S_CLEAR_END: begin
        stb.rst_address = 1'b1;
        state_n         = S_INIT_HEAD;
      end
      S_INIT_HEAD: begin
        stb.ld_head = 1'b1;
        state_n     = S_INIT_Q;
      end
      S_INIT_Q: begin
        stb.ld_q_def    = 1'b1;
        stb.inc_address = 1'b1;
        if (idx == INIT_LAST) begin
          idx_n   = '0;
          state_n = S_INIT_END;
        end else begin
          idx_n = idx + 11'd1;
        end
      end
      S_INIT_END: begin
        stb.rst_address = 1'b1;
        len_n           = LEN_INIT;
        state_n         = S_DRAW_Q;
      end
      S_DRAW_Q: begin
        colour     = 3'b010;
        stb.draw_q = 1'b1;
        if (cnt == 4'd15) begin
          cnt_n   = '0;
          state_n = S_DRAW_INC;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_DRAW_INC: begin
        colour          = 3'b010;
        stb.inc_address = 1'b1;
        if (idx == len - 11'd1) begin
          idx_n   = '0;
          state_n = S_FOOD;
        end else begin
          idx_n   = idx + 11'd1;
          state_n = S_DRAW_Q;
        end
      end
      S_FOOD: begin
        colour      = 3'b001;
        stb.food_en = 1'b1;
        if (cnt == 4'd15) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_WAIT: begin
        if (bus.tick) state_n = S_MOVE;
      end
      S_MOVE: begin
        stb.update_head       = 1'b1;
        stb.ld_head_into_prev = 1'b1;
        stb.rst_address       = 1'b1;
        state_n               = S_SHIFT_RD;
      end
      S_SHIFT_RD: begin
        state_n = S_SHIFT_CAP;
      end
      S_SHIFT_CAP: begin
        stb.ld_q_into_curr = 1'b1;
        state_n            = S_SHIFT_WR;
      end
      S_SHIFT_WR: begin
        stb.ld_prev_into_q = 1'b1;
        state_n            = S_SHIFT_NX;
      end
      S_SHIFT_NX: begin
        stb.ld_curr_into_prev = 1'b1;
        stb.inc_address       = 1'b1;
        if (idx == len - 11'd1) begin
          idx_n   = '0;
          state_n = S_ERASE;
        end else begin
          idx_n   = idx + 11'd1;
          state_n = S_SHIFT_RD;
        end
      end
      S_ERASE: begin
        stb.draw_curr = 1'b1;
        if (cnt == 4'd15) begin
          cnt_n   = '0;
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_CHECK: begin
        stb.lock      = 1'b1;
        stb.check_inc = 1'b1;
        if (bus.is_dead) begin
          state_n = S_DEAD;
        end else begin
          if (bus.inc_length && (len < LEN_MAX)) len_n = len + 11'd1;
          state_n = S_REDRAW;
        end
      end
      S_REDRAW: begin
        stb.rst_address = 1'b1;
        state_n         = S_DRAW_Q;
      end
      S_DEAD: begin
        colour = 3'b100;
        if (bus.start) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = S_CLEAR;
        end
      end
      default: begin
        state_n = S_CLEAR;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // The reset state decodes to clearing strobes, so outputs are forced
  // low while rst is held to keep the datapath quiet during reset.
  assign stb_g    = rst ? stb : '0;
  assign colour_g = rst ? colour : 3'b000;

  // Direction request decode: exactly one key, and never a 180-degree turn.
  always_comb begin
    keys     = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
    key_code = dir;
    case (keys)
      4'b1000: key_code = D_UP;
      4'b0100: key_code = D_DOWN;
      4'b0010: key_code = D_LEFT;
      4'b0001: key_code = D_RIGHT;
      default: key_code = dir;
    endcase
    case (dir)
      D_UP:    dir_rev = D_DOWN;
      D_DOWN:  dir_rev = D_UP;
      D_LEFT:  dir_rev = D_RIGHT;
      D_RIGHT: dir_rev = D_LEFT;
      default: dir_rev = dir;
    endcase
    dir_ok = $onehot(keys) && (key_code != dir_rev);
  end

  // Direction register, updated in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dir <= D_UP;
    else if (dir_ok) dir <= key_code;
  end

  assign bus.dir               = dir;
  assign bus.cnt_status        = cnt;
  assign bus.colour_in         = colour_g;
  assign bus.reset_ram         = stb_g.reset_ram;
  assign bus.rst_address       = stb_g.rst_address;
  assign bus.inc_address       = stb_g.inc_address;
  assign bus.ld_head           = stb_g.ld_head;
  assign bus.ld_q_def          = stb_g.ld_q_def;
  assign bus.draw_q            = stb_g.draw_q;
  assign bus.update_head       = stb_g.update_head;
  assign bus.ld_head_into_prev = stb_g.ld_head_into_prev;
  assign bus.ld_q_into_curr    = stb_g.ld_q_into_curr;
  assign bus.ld_prev_into_q    = stb_g.ld_prev_into_q;
  assign bus.ld_curr_into_prev = stb_g.ld_curr_into_prev;
  assign bus.draw_curr         = stb_g.draw_curr;
  assign bus.food_en           = stb_g.food_en;
  assign bus.lock              = stb_g.lock;
  assign bus.check_inc         = stb_g.check_inc;
  assign bus.state_dbg         = state;

endmodule

// File: doc/snake_control.md
SNAKE_CONTROL -- requirements
Module: snake_control

Interface
REQ-001 SHALL have the following parameters: INIT_LEN, default 4, initial segment count; MAX_LEN, default 2047, segment-count ceiling; CLEAR_WORDS, default 2048, RAM words cleared.
REQ-002 SHALL have the following ports (name, direction, width, meaning), listed clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- tick  in  1  one-cycle game-step pulse.
- start  in  1  level; restarts the game from S_DEAD.
- key_up  in  1  direction request, level.
- key_down  in  1  direction request, level.
- key_left  in  1  direction request, level.
- key_right  in  1  direction request, level.
- is_dead  in  1  collision flag from the datapath.
- inc_length  in  1  food-eaten flag from the datapath; valid while check_inc is high.
- dir  out  3  registered direction: UP=100, DOWN=110, LEFT=000, RIGHT=001.
- cnt_status  out  4  sub-pixel counter.
- colour_in  out  3  draw colour.
- Strobes, each out 1: reset_ram, rst_address, inc_address, ld_head, ld_q_def, draw_q, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, lock, check_inc.

Function
REQ-003 All outputs SHALL be Moore outputs decoded from the state register only; cnt_status SHALL equal the internal counter cnt[3:0].
REQ-004 The internal registers SHALL be: state; cnt[3:0]; idx[10:0]; len[10:0].
REQ-005 S_CLEAR SHALL assert reset_ram and inc_address every cycle for CLEAR_WORDS cycles (idx 0..CLEAR_WORDS-1), then assert rst_address for one cycle and enter S_INIT.
REQ-006 S_INIT SHALL do the following:
- Assert ld_head in its first cycle.
- Then assert ld_q_def with inc_address for INIT_LEN cycles.
- Then assert rst_address for one cycle, set len=INIT_LEN, and enter S_DRAW.
REQ-007 S_DRAW SHALL, for each idx 0..len-1, assert draw_q for 16 cycles with cnt 0..15, then assert inc_address for one cycle; after the last segment it SHALL enter S_FOOD.
REQ-008 S_FOOD SHALL assert food_en for 16 cycles (cnt 0..15), then enter S_WAIT.
REQ-009 In S_WAIT, a tick pulse SHALL cause the following:
- One S_MOVE cycle asserting update_head, ld_head_into_prev and rst_address together.
- Then entry to S_SHIFT.
- A tick arriving in any other state SHALL be ignored.
REQ-010 S_SHIFT SHALL process each idx 0..len-1 as the four-cycle sequence RD, CAP, WR, NX:
- RD: no strobe (RAM read latency).
- CAP: ld_q_into_curr.
- WR: ld_prev_into_q.
- NX: ld_curr_into_prev and inc_address.
REQ-011 After the final NX, S_SHIFT SHALL enter S_ERASE.
REQ-012 S_ERASE SHALL assert draw_curr with colour_in=000 for 16 cycles, then enter S_CHECK.
REQ-013 S_CHECK SHALL assert lock and check_inc for one cycle and then act as follows:
- If is_dead: enter S_DEAD.
- Else if inc_length: set len=min(len+1, MAX_LEN), assert rst_address, and enter S_DRAW.
- Else: assert rst_address and enter S_DRAW.
REQ-014 S_DEAD SHALL hold all strobes low with colour_in=100, and SHALL enter S_CLEAR with idx=0 on start=1.
REQ-015 colour_in SHALL be 010 in S_DRAW, 001 in S_FOOD, 000 in S_ERASE, 100 in S_DEAD, and 000 otherwise.
REQ-016 dir SHALL update in any state, on the cycle after exactly one key is high, to that key's code.
REQ-017 dir SHALL NOT update when that key's code is the 180-degree reverse of the current dir (UP/DOWN, LEFT/RIGHT), nor when two or more keys are high.
REQ-018 cnt and idx SHALL wrap to 0 on each phase exit, and no counter SHALL overflow its width.
REQ-019 is_dead asserted outside S_CHECK SHALL be ignored until the next S_CHECK.

Reset
REQ-020 rst=0 SHALL force, asynchronously: state=S_CLEAR, cnt=0, idx=0, len=INIT_LEN, dir=UP (100), and all strobes and colour_in equal to 0.
REQ-021 Reset asserted mid-phase SHALL abort that phase, and after release the block SHALL restart S_CLEAR at idx=0.

Verification
REQ-022 Release reset -> reset_ram high for exactly 2048 cycles, then rst_address high for 1 cycle, ld_head high for 1 cycle, and ld_q_def high for 4 cycles.
REQ-023 After init with no tick -> 4x17 draw_q/inc_address cycles, then 16 food_en cycles with colour_in=001, then S_WAIT held indefinitely.
REQ-024 tick in S_WAIT with len=4 -> one update_head cycle, then 16 shift cycles with the strobe pattern RD/CAP/WR/NX repeated 4 times, then 16 draw_curr cycles with colour_in=000, then one check_inc cycle.
REQ-025 inc_length=1 during check_inc -> len=5, and the next S_DRAW issues 5x17 cycles; with len=2047, inc_length keeps len at 2047.
REQ-026 Direction keys, starting from dir=UP:
- key_down alone -> dir stays 100.
- key_left alone -> dir becomes 000.
- key_right with key_up together -> dir unchanged.
REQ-027 is_dead=1 at S_CHECK -> S_DEAD with colour_in=100; start=1 -> S_CLEAR; rst=0 pulsed mid-S_SHIFT -> all strobes 0 immediately and a fresh 2048-cycle clear follows.
